// File: rtl/pixel_plot_writer_if.sv
// Pixel-stream and framebuffer-write bundle for pixel_plot_writer.
// master = upstream generator / arbiter side, slave = the writer block.
interface pixel_plot_writer_if #(
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 15
);
  logic               PIX_VALID;
  logic               PIX_READY;
  logic [7:0]         PIX_X;
  logic [7:0]         PIX_Y;
  logic [COLOR_W-1:0] PIX_COLOR;
  logic               PIX_LAST;
  logic               MEM_GNT;
  logic               MEM_WE;
  logic [ADDR_W-1:0]  MEM_ADDR;
  logic [COLOR_W-1:0] MEM_DATA;
  logic               BUSY;
  logic               DONE;

  modport master (
    output PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, PIX_LAST, MEM_GNT,
    input  PIX_READY, MEM_WE, MEM_ADDR, MEM_DATA, BUSY, DONE
  );

  modport slave (
    input  PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, PIX_LAST, MEM_GNT,
    output PIX_READY, MEM_WE, MEM_ADDR, MEM_DATA, BUSY, DONE
  );
endinterface

// File: rtl/pixel_plot_writer.sv
// Buffers (x, y, colour) plots, clips them to the framebuffer and issues granted writes.
// Optional PIXEL_PLOT_CLIP_COUNT_EN adds a saturating CLIP_CNT output.
module pixel_plot_writer #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 15
) (
  input  logic ACLK,
  input  logic RST,
  pixel_plot_writer_if.slave bus
`ifdef PIXEL_PLOT_CLIP_COUNT_EN
  ,
  output logic [15:0] CLIP_CNT
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [31:0] FB_W_U = 32'(FB_W);
  localparam logic [31:0] FB_H_U = 32'(FB_H);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [7:0]         r_fifoX     [FIFO_DEPTH];
  logic [7:0]         r_fifoY     [FIFO_DEPTH];
  logic [COLOR_W-1:0] r_fifoColor [FIFO_DEPTH];
  logic               r_fifoLast  [FIFO_DEPTH];

  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic               r_ready;
  logic               r_outValid;
  logic               r_outLast;
  logic [ADDR_W-1:0]  r_memAddr;
  logic [COLOR_W-1:0] r_memData;
  logic               r_busy;
  logic               r_done;

  logic               w_push;
  logic               w_retire;
  logic               w_pop;
  logic               w_clip;
  logic [7:0]         w_headX;
  logic [7:0]         w_headY;
  logic [COLOR_W-1:0] w_headColor;
  logic               w_headLast;
  logic [31:0]        w_addrFull;
  logic [PTR_W:0]     w_nextCount;
  logic               w_nextOutValid;

  // READY is zero whenever the FIFO is full, so a full FIFO never pushes even on a pop.
  assign w_push      = bus.PIX_VALID && r_ready;
  assign w_retire    = r_outValid && bus.MEM_GNT;
  assign w_pop       = (r_count != '0) && (!r_outValid || w_retire);
  assign w_headX     = r_fifoX[r_rptr];
  assign w_headY     = r_fifoY[r_rptr];
  assign w_headColor = r_fifoColor[r_rptr];
  assign w_headLast  = r_fifoLast[r_rptr];
  assign w_clip      = (32'(w_headX) >= FB_W_U) || (32'(w_headY) >= FB_H_U);
  assign w_addrFull  = 32'(w_headY) * FB_W_U + 32'(w_headX);
  assign w_nextCount = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
  assign w_nextOutValid = (w_pop && !w_clip) ? 1'b1 : (w_retire ? 1'b0 : r_outValid);

  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_fifoX[r_wptr]     <= bus.PIX_X;
      r_fifoY[r_wptr]     <= bus.PIX_Y;
      r_fifoColor[r_wptr] <= bus.PIX_COLOR;
      r_fifoLast[r_wptr]  <= bus.PIX_LAST;
    end
  end

  always_ff @(posedge ACLK) begin
    if (RST) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_memAddr  <= '0;
      r_memData  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count    <= w_nextCount;
      r_ready    <= w_nextCount < DEPTH_C;
      r_outValid <= w_nextOutValid;
      // Address and data only change when a surviving head loads the stage.
      if (w_pop && !w_clip) begin
        r_memAddr <= w_addrFull[ADDR_W-1:0];
        r_memData <= w_headColor;
        r_outLast <= w_headLast;
      end
      r_busy <= (w_nextCount != '0) || w_nextOutValid;
      r_done <= (w_retire && r_outLast) || (w_pop && w_clip && w_headLast);
    end
  end

`ifdef PIXEL_PLOT_CLIP_COUNT_EN
  logic [15:0] r_clipCnt;

  always_ff @(posedge ACLK) begin
    if (RST) begin
      r_clipCnt <= '0;
    end else if (w_pop && w_clip && (r_clipCnt != 16'hFFFF)) begin
      r_clipCnt <= r_clipCnt + 16'd1;
    end
  end

  assign CLIP_CNT = r_clipCnt;
`endif

  assign bus.PIX_READY = r_ready;
  assign bus.MEM_WE    = r_outValid;
  assign bus.MEM_ADDR  = r_memAddr;
  assign bus.MEM_DATA  = r_memData;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
endmodule

// File: tb/tb_pixel_plot_writer.sv
// Directed self-checking bench for pixel_plot_writer with hand-computed expectations.
// Build with +define+PIXEL_PLOT_CLIP_COUNT_EN to also check CLIP_CNT.
module tb_pixel_plot_writer;
  logic ACLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;
  int   cycleCnt = 0;
  int   doneCnt = 0;
  int   wrAddr[$];
  int   wrData[$];
  int   wrCycle[$];

  pixel_plot_writer_if #(.COLOR_W(8), .ADDR_W(15)) bus ();

`ifdef PIXEL_PLOT_CLIP_COUNT_EN
  logic [15:0] clipCnt;
`endif

  pixel_plot_writer #(
    .FB_W(160), .FB_H(120), .COLOR_W(8), .FIFO_DEPTH(8), .ADDR_W(15)
  ) dut (
    .ACLK(ACLK),
    .RST(RST),
    .bus(bus)
`ifdef PIXEL_PLOT_CLIP_COUNT_EN
    ,
    .CLIP_CNT(clipCnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  // Records every retired write and every DONE pulse seen at a clock edge.
  always @(posedge ACLK) begin
    cycleCnt++;
    if (!RST && bus.MEM_WE && bus.MEM_GNT) begin
      wrAddr.push_back(int'(bus.MEM_ADDR));
      wrData.push_back(int'(bus.MEM_DATA));
      wrCycle.push_back(cycleCnt);
    end
    if (!RST && bus.DONE) doneCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  // Offers one pixel and returns #1 after the edge at which it was accepted.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [7:0] c,
                               input logic last, input string tag);
    logic wasReady;
    logic accepted;
    accepted = 1'b0;
    bus.PIX_X = x;
    bus.PIX_Y = y;
    bus.PIX_COLOR = c;
    bus.PIX_LAST = last;
    bus.PIX_VALID = 1'b1;
    for (int i = 0; i < 40 && !accepted; i++) begin
      wasReady = bus.PIX_READY;
      @(posedge ACLK);
      #1;
      if (wasReady) accepted = 1'b1;
    end
    bus.PIX_VALID = 1'b0;
    checkOutput({tag, "_accepted"}, 32'(accepted), 32'd1);
  endtask

  initial begin
    int base;
    int doneBase;
    int k;
    int accepted;
    logic wasReady;
    logic offer;

    RST = 1'b1;
    bus.PIX_VALID = 1'b0;
    bus.PIX_X = '0;
    bus.PIX_Y = '0;
    bus.PIX_COLOR = '0;
    bus.PIX_LAST = 1'b0;
    bus.MEM_GNT = 1'b1;
    tick(2);
    checkOutput("rst_ready", 32'(bus.PIX_READY), 32'd0);
    checkOutput("rst_we",    32'(bus.MEM_WE),    32'd0);
    checkOutput("rst_addr",  32'(bus.MEM_ADDR),  32'd0);
    checkOutput("rst_data",  32'(bus.MEM_DATA),  32'd0);
    checkOutput("rst_busy",  32'(bus.BUSY),      32'd0);
    checkOutput("rst_done",  32'(bus.DONE),      32'd0);
`ifdef PIXEL_PLOT_CLIP_COUNT_EN
    checkOutput("rst_clipcnt", 32'(clipCnt), 32'd0);
`endif
    RST = 1'b0;
    tick(1);
    checkOutput("ready_after_rst", 32'(bus.PIX_READY), 32'd1);

    // Single in-range pixel: 5*160+10 = 810.
    base = wrAddr.size();
    applyStimulus(8'd10, 8'd5, 8'h3C, 1'b1, "single");
    checkOutput("single_busy_e0", 32'(bus.BUSY), 32'd1);
    tick(1);
    checkOutput("single_we",   32'(bus.MEM_WE),   32'd1);
    checkOutput("single_addr", 32'(bus.MEM_ADDR), 32'd810);
    checkOutput("single_data", 32'(bus.MEM_DATA), 32'h3C);
    checkOutput("single_done_early", 32'(bus.DONE), 32'd0);
    tick(1);
    checkOutput("single_we_off", 32'(bus.MEM_WE), 32'd0);
    checkOutput("single_done",   32'(bus.DONE),   32'd1);
    checkOutput("single_busy",   32'(bus.BUSY),   32'd0);
    tick(1);
    checkOutput("single_done_pulse", 32'(bus.DONE), 32'd0);
    checkOutput("single_nwrites", 32'(wrAddr.size() - base), 32'd1);

    // Clipped last pixel.
    base = wrAddr.size();
    doneBase = doneCnt;
    applyStimulus(8'd200, 8'd5, 8'h11, 1'b1, "clip");
    tick(1);
    checkOutput("clip_we",   32'(bus.MEM_WE), 32'd0);
    checkOutput("clip_done", 32'(bus.DONE),   32'd1);
    tick(1);
    checkOutput("clip_done_pulse", 32'(bus.DONE), 32'd0);
    checkOutput("clip_busy", 32'(bus.BUSY), 32'd0);
    tick(2);
    checkOutput("clip_nwrites", 32'(wrAddr.size() - base), 32'd0);
    checkOutput("clip_ndone",   32'(doneCnt - doneBase),   32'd1);
`ifdef PIXEL_PLOT_CLIP_COUNT_EN
    checkOutput("clip_clipcnt", 32'(clipCnt), 32'd1);
`endif

    // Boundaries: 119*160+159 = 19199; x=160 and y=120 clip.
    applyStimulus(8'd159, 8'd119, 8'h55, 1'b0, "corner");
    tick(1);
    checkOutput("corner_we",   32'(bus.MEM_WE),   32'd1);
    checkOutput("corner_addr", 32'(bus.MEM_ADDR), 32'd19199);
    checkOutput("corner_data", 32'(bus.MEM_DATA), 32'h55);
    tick(3);
    base = wrAddr.size();
    doneBase = doneCnt;
    applyStimulus(8'd160, 8'd0, 8'h66, 1'b0, "xedge");
    applyStimulus(8'd0, 8'd120, 8'h67, 1'b1, "yedge");
    tick(4);
    checkOutput("edge_nwrites", 32'(wrAddr.size() - base), 32'd0);
    checkOutput("edge_ndone",   32'(doneCnt - doneBase),   32'd1);
    checkOutput("edge_addr_held", 32'(bus.MEM_ADDR), 32'd19199);
`ifdef PIXEL_PLOT_CLIP_COUNT_EN
    checkOutput("edge_clipcnt", 32'(clipCnt), 32'd3);
`endif

    // Backpressure: 12 pixels at (k, 2) with grant held low, then released.
    bus.MEM_GNT = 1'b0;
    base = wrAddr.size();
    doneBase = doneCnt;
    k = 0;
    accepted = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      offer = (k < 12);
      bus.PIX_VALID = offer;
      bus.PIX_X = 8'(k);
      bus.PIX_Y = 8'd2;
      bus.PIX_COLOR = 8'(8'h80 + k);
      bus.PIX_LAST = (k == 11);
      wasReady = bus.PIX_READY;
      tick(1);
      if (offer && wasReady) begin
        k++;
        accepted++;
      end
    end
    checkOutput("bp_accepted", 32'(accepted), 32'd9);
    checkOutput("bp_ready",    32'(bus.PIX_READY), 32'd0);
    checkOutput("bp_busy",     32'(bus.BUSY), 32'd1);
    checkOutput("bp_nowrites", 32'(wrAddr.size() - base), 32'd0);
    bus.MEM_GNT = 1'b1;
    for (int cyc = 0; cyc < 40 && k < 12; cyc++) begin
      offer = 1'b1;
      bus.PIX_VALID = offer;
      bus.PIX_X = 8'(k);
      bus.PIX_Y = 8'd2;
      bus.PIX_COLOR = 8'(8'h80 + k);
      bus.PIX_LAST = (k == 11);
      wasReady = bus.PIX_READY;
      tick(1);
      if (wasReady) k++;
    end
    bus.PIX_VALID = 1'b0;
    tick(15);
    checkOutput("bp_nwrites", 32'(wrAddr.size() - base), 32'd12);
    checkOutput("bp_ndone",   32'(doneCnt - doneBase),   32'd1);
    if (wrAddr.size() - base == 12) begin
      for (int i = 0; i < 12; i++) begin
        checkOutput($sformatf("bp_addr%0d", i), 32'(wrAddr[base+i]), 32'(320 + i));
        checkOutput($sformatf("bp_data%0d", i), 32'(wrData[base+i]), 32'(8'h80 + i));
      end
      for (int i = 1; i < 9; i++) begin
        checkOutput($sformatf("bp_gap%0d", i), 32'(wrCycle[base+i] - wrCycle[base+i-1]), 32'd1);
      end
    end

    // Grant stalls 0,0,1: 10*160+20 = 1620.
    bus.MEM_GNT = 1'b0;
    base = wrAddr.size();
    doneBase = doneCnt;
    applyStimulus(8'd20, 8'd10, 8'h77, 1'b1, "stall");
    tick(1);
    checkOutput("stall_we0",   32'(bus.MEM_WE),   32'd1);
    checkOutput("stall_addr0", 32'(bus.MEM_ADDR), 32'd1620);
    tick(1);
    checkOutput("stall_we1",   32'(bus.MEM_WE),   32'd1);
    checkOutput("stall_addr1", 32'(bus.MEM_ADDR), 32'd1620);
    checkOutput("stall_data1", 32'(bus.MEM_DATA), 32'h77);
    tick(1);
    checkOutput("stall_addr2", 32'(bus.MEM_ADDR), 32'd1620);
    checkOutput("stall_data2", 32'(bus.MEM_DATA), 32'h77);
    checkOutput("stall_nowrite", 32'(wrAddr.size() - base), 32'd0);
    bus.MEM_GNT = 1'b1;
    tick(1);
    checkOutput("stall_we_off", 32'(bus.MEM_WE), 32'd0);
    checkOutput("stall_done",   32'(bus.DONE),   32'd1);
    tick(3);
    checkOutput("stall_nwrites", 32'(wrAddr.size() - base), 32'd1);
    checkOutput("stall_ndone",   32'(doneCnt - doneBase),   32'd1);

    // Reset mid-run with four pixels pending.
    bus.MEM_GNT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'(40 + i), 8'd3, 8'(8'h20 + i), (i == 3), "mid");
    end
    tick(1);
    checkOutput("mid_busy_pre", 32'(bus.BUSY), 32'd1);
    base = wrAddr.size();
    doneBase = doneCnt;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    checkOutput("mid_we",    32'(bus.MEM_WE),    32'd0);
    checkOutput("mid_busy",  32'(bus.BUSY),      32'd0);
    checkOutput("mid_ready", 32'(bus.PIX_READY), 32'd0);
    checkOutput("mid_done",  32'(bus.DONE),      32'd0);
    tick(1);
    checkOutput("mid_ready_back", 32'(bus.PIX_READY), 32'd1);
    bus.MEM_GNT = 1'b1;
    tick(6);
    checkOutput("mid_nwrites", 32'(wrAddr.size() - base), 32'd0);
    checkOutput("mid_ndone",   32'(doneCnt - doneBase),   32'd0);
    checkOutput("mid_busy_post", 32'(bus.BUSY), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
